cam_pixel_fifo_drain: RTL and testbench

- Read-side controller for the 32-bit camera pixel remap FIFO (standard mode, registered output).
- Issues rd_en to the FIFO under credit control and absorbs the FIFO read latency in a small internal skid buffer.
- Presents pixels downstream as a valid/ready stream, with start-of-frame (tuser) and end-of-line (tlast) markers generated from line/frame counters.
- Sits between the remap FIFO and the DMA/display stream input.

---
 rtl/cam_pixel_fifo_drain.sv | 172 +++++++++++++++++
 tb/tb_cam_pixel_fifo_drain.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cam_pixel_fifo_drain.sv
// Read-side drain for the camera pixel remap FIFO: credit-limited rd_en, skid buffer, AXI-stream-style output.
// Optional macro CAM_PIXEL_FIFO_DRAIN_STATS_EN adds frame_cnt_o and stall_cnt_o.
module cam_pixel_fifo_drain #(
  parameter int DATA_WIDTH = 32,
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int RD_LATENCY = 2,
  parameter int BUF_DEPTH  = 4
) (
  input  logic                  clk_i,
  input  logic                  a_rstn_i,
  input  logic                  enable_i,
  input  logic                  clr_i,
  input  logic                  fifo_empty_i,
  input  logic                  fifo_rd_valid_i,
  input  logic [DATA_WIDTH-1:0] fifo_rdata_i,
  output logic                  fifo_rd_en_o,
  output logic                  m_tvalid_o,
  input  logic                  m_tready_i,
  output logic [DATA_WIDTH-1:0] m_tdata_o,
  output logic                  m_tuser_o,
  output logic                  m_tlast_o,
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
  output logic [15:0]           frame_cnt_o,
  output logic [31:0]           stall_cnt_o,
`endif
  output logic                  err_spurious_o,
  output logic                  err_overrun_o
);

  localparam int PW = $clog2(BUF_DEPTH);
  localparam int CW = PW + 1;
  localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
  localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(BUF_DEPTH);
  localparam logic [CW:0]   OCC_MAX  = (CW+1)'(BUF_DEPTH);
  localparam logic [XW-1:0] X_LAST   = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] Y_LAST   = YW'(V_ACTIVE - 1);

  if (BUF_DEPTH < RD_LATENCY + 2 || (BUF_DEPTH & (BUF_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("BUF_DEPTH must be a power of 2 and >= RD_LATENCY+2");
  end

  logic                  run_q, run_d;
  logic [CW-1:0]         inflight_q, inflight_d;
  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [XW-1:0]         x_q, x_d;
  logic [YW-1:0]         y_q, y_d;
  logic                  err_sp_q, err_sp_d;
  logic                  err_ov_q, err_ov_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
  logic [15:0]           frame_cnt_q, frame_cnt_d;
  logic [31:0]           stall_cnt_q, stall_cnt_d;
`endif

  logic          rd_en, pop, push, full, dec_ok, x_wrap, y_wrap, mem_we;
  logic [CW:0]   occ;

  always_comb begin
    occ    = {1'b0, count_q} + {1'b0, inflight_q};
    rd_en  = run_q & enable_i & ~fifo_empty_i & ~clr_i & (occ < OCC_MAX);
    full   = (count_q == DEPTH_C);
    pop    = (count_q != '0) & m_tready_i;
    // A full buffer can still take a word when the head leaves in the same cycle.
    push   = fifo_rd_valid_i & (~full | pop);
    dec_ok = fifo_rd_valid_i & (inflight_q != '0);
    x_wrap = (x_q == X_LAST);
    y_wrap = (y_q == Y_LAST);
    mem_we = push & ~clr_i;

    run_d      = 1'b1;
    inflight_d = inflight_q;
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    x_d        = x_q;
    y_d        = y_q;
    err_sp_d   = err_sp_q;
    err_ov_d   = err_ov_q;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
    frame_cnt_d = frame_cnt_q;
    stall_cnt_d = stall_cnt_q;
`endif

    if (clr_i) begin
      inflight_d = '0;
      count_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      x_d        = '0;
      y_d        = '0;
      err_sp_d   = 1'b0;
      err_ov_d   = 1'b0;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
      frame_cnt_d = '0;
      stall_cnt_d = '0;
`endif
    end else begin
      inflight_d = inflight_q + CW'(rd_en) - CW'(dec_ok);
      count_d    = count_q + CW'(push) - CW'(pop);
      wr_ptr_d   = wr_ptr_q + PW'(push);
      rd_ptr_d   = rd_ptr_q + PW'(pop);
      err_sp_d   = err_sp_q | (fifo_rd_valid_i & (inflight_q == '0));
      err_ov_d   = err_ov_q | (fifo_rd_valid_i & full & ~pop);
      if (pop) begin
        if (x_wrap) begin
          x_d = '0;
          y_d = y_wrap ? '0 : y_q + YW'(1);
        end else begin
          x_d = x_q + XW'(1);
        end
      end
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
      if (pop & x_wrap & y_wrap) frame_cnt_d = frame_cnt_q + 16'd1;
      if ((count_q != '0) & ~m_tready_i & (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 32'd1;
`endif
    end
  end

  always_ff @(posedge clk_i or negedge a_rstn_i) begin
    if (!a_rstn_i) begin
      run_q      <= 1'b0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      x_q        <= '0;
      y_q        <= '0;
      err_sp_q   <= 1'b0;
      err_ov_q   <= 1'b0;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
      frame_cnt_q <= '0;
      stall_cnt_q <= '0;
`endif
    end else begin
      run_q      <= run_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      x_q        <= x_d;
      y_q        <= y_d;
      err_sp_q   <= err_sp_d;
      err_ov_q   <= err_ov_d;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
      frame_cnt_q <= frame_cnt_d;
      stall_cnt_q <= stall_cnt_d;
`endif
    end
  end

  // Storage needs no reset: the head is masked to zero whenever the buffer is empty.
  always_ff @(posedge clk_i) begin
    if (mem_we) mem_q[wr_ptr_q] <= fifo_rdata_i;
  end

  assign fifo_rd_en_o   = rd_en;
  assign m_tvalid_o     = (count_q != '0);
  assign m_tdata_o      = m_tvalid_o ? mem_q[rd_ptr_q] : '0;
  assign m_tuser_o      = (x_q == '0) & (y_q == '0);
  assign m_tlast_o      = x_wrap;
  assign err_spurious_o = err_sp_q;
  assign err_overrun_o  = err_ov_q;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
  assign frame_cnt_o    = frame_cnt_q;
  assign stall_cnt_o    = stall_cnt_q;
`endif

endmodule

// File: tb/tb_cam_pixel_fifo_drain.sv
// Directed bench for cam_pixel_fifo_drain with a 2-cycle-latency FIFO model; H_ACTIVE=4, V_ACTIVE=2.
module tb_cam_pixel_fifo_drain;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          a_rstn = 1'b0;
  logic          enable = 1'b0;
  logic          clr = 1'b0;
  logic          fifo_empty;
  logic          fifo_rd_valid;
  logic [DW-1:0] fifo_rdata;
  logic          fifo_rd_en;
  logic          m_tvalid;
  logic          m_tready = 1'b0;
  logic [DW-1:0] m_tdata;
  logic          m_tuser;
  logic          m_tlast;
  logic          err_sp;
  logic          err_ov;
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
  logic [15:0]   frame_cnt;
  logic [31:0]   stall_cnt;
`endif

  always #5 clk = ~clk;

  cam_pixel_fifo_drain #(
    .DATA_WIDTH(DW), .H_ACTIVE(4), .V_ACTIVE(2), .RD_LATENCY(2), .BUF_DEPTH(4)
  ) dut (
    .clk_i(clk), .a_rstn_i(a_rstn), .enable_i(enable), .clr_i(clr),
    .fifo_empty_i(fifo_empty), .fifo_rd_valid_i(fifo_rd_valid), .fifo_rdata_i(fifo_rdata),
    .fifo_rd_en_o(fifo_rd_en), .m_tvalid_o(m_tvalid), .m_tready_i(m_tready),
    .m_tdata_o(m_tdata), .m_tuser_o(m_tuser), .m_tlast_o(m_tlast),
`ifdef CAM_PIXEL_FIFO_DRAIN_STATS_EN
    .frame_cnt_o(frame_cnt), .stall_cnt_o(stall_cnt),
`endif
    .err_spurious_o(err_sp), .err_overrun_o(err_ov)
  );

  // FIFO model: rd_en sampled mid-cycle, data returns two cycles after the read edge.
  logic [DW-1:0] fq [$];
  int            fq_n = 0;
  logic          v1, v2;
  logic [DW-1:0] d1, d2;
  logic          inj = 1'b0;
  logic [DW-1:0] inj_d = '0;
  logic          rd_en_s = 1'b0;

  assign fifo_empty    = (fq_n == 0);
  assign fifo_rd_valid = v2 | inj;
  assign fifo_rdata    = inj ? inj_d : d2;

  always @(posedge clk or negedge a_rstn) begin
    if (!a_rstn) begin
      v1 <= 1'b0; v2 <= 1'b0; d1 <= '0; d2 <= '0;
    end else begin
      v2 <= v1;
      d2 <= d1;
      v1 <= rd_en_s;
      if (rd_en_s && fq.size() > 0) begin
        d1 <= fq.pop_front();
        fq_n = fq_n - 1;
      end
    end
  end

  // Monitor: records accepted beats and tracks reads issued minus beats accepted.
  logic [DW-1:0] bq_d [$];
  logic          bq_u [$];
  logic          bq_l [$];
  int            rd_cnt = 0;
  int            hs_cnt = 0;
  int            occ_max = 0;
  logic          track = 1'b0;

  always @(negedge clk) begin
    rd_en_s = fifo_rd_en;
    if (fifo_rd_en) rd_cnt = rd_cnt + 1;
    if (m_tvalid && m_tready) begin
      bq_d.push_back(m_tdata);
      bq_u.push_back(m_tuser);
      bq_l.push_back(m_tlast);
      hs_cnt = hs_cnt + 1;
    end
    if (track && (rd_cnt - hs_cnt) > occ_max) occ_max = rd_cnt - hs_cnt;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [DW-1:0] w);
    fq.push_back(w);
    fq_n = fq_n + 1;
  endtask

  task automatic clear_beats();
    bq_d.delete();
    bq_u.delete();
    bq_l.delete();
  endtask

  task automatic wait_beats(input int n, input int budget);
    int c;
    c = 0;
    while (bq_d.size() < n && c < budget) begin
      tick();
      c++;
    end
    chk("beats_arrived", 32'(bq_d.size()), 32'(n));
  endtask

  initial begin
    int rd_base;
    int pos;

    // Reset state, with a readable FIFO and enable high
    enable = 1'b1;
    m_tready = 1'b1;
    for (int i = 0; i < 8; i++) push_word(32'(i));
    repeat (2) @(posedge clk);
    #3;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    chk("rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("rst_tdata", m_tdata, 32'd0);
    chk("rst_tuser", 32'(m_tuser), 32'd1);
    chk("rst_tlast", 32'(m_tlast), 32'd0);
    chk("rst_err_sp", 32'(err_sp), 32'd0);
    chk("rst_err_ov", 32'(err_ov), 32'd0);
    tick();
    a_rstn = 1'b1;

    // Test 1: first read in cycle 1, data 0..7 back to back from cycle 4
    @(negedge clk);
    chk("t1_rd_en_c0", 32'(fifo_rd_en), 32'd0);
    @(negedge clk);
    chk("t1_rd_en_c1", 32'(fifo_rd_en), 32'd1);
    @(negedge clk);
    @(negedge clk);
    chk("t1_tvalid_c3", 32'(m_tvalid), 32'd0);
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      chk("t1_tvalid", 32'(m_tvalid), 32'd1);
      chk("t1_tdata", m_tdata, 32'(k));
      chk("t1_tuser", 32'(m_tuser), (k == 0) ? 32'd1 : 32'd0);
      chk("t1_tlast", 32'(m_tlast), (k % 4 == 3) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t1_tvalid_end", 32'(m_tvalid), 32'd0);
    chk("t1_err_sp", 32'(err_sp), 32'd0);
    chk("t1_err_ov", 32'(err_ov), 32'd0);

    // Test 2: 16 beats, tlast every 4th, tuser every 8th
    tick();
    clear_beats();
    for (int i = 0; i < 16; i++) push_word(32'(100 + i));
    wait_beats(16, 100);
    for (int i = 0; i < 16 && i < bq_d.size(); i++) begin
      chk("t2_data", bq_d[i], 32'(100 + i));
      chk("t2_tuser", 32'(bq_u[i]), (i % 8 == 0) ? 32'd1 : 32'd0);
      chk("t2_tlast", 32'(bq_l[i]), (i % 4 == 3) ? 32'd1 : 32'd0);
    end

    // Test 3: ready low with a deep FIFO, exactly BUF_DEPTH reads then hold
    repeat (4) tick();
    m_tready = 1'b0;
    rd_base = rd_cnt;
    for (int i = 0; i < 10; i++) push_word(32'(200 + i));
    repeat (10) tick();
    chk("t3_tdata_mid", m_tdata, 32'd200);
    repeat (10) tick();
    chk("t3_rd_count", 32'(rd_cnt - rd_base), 32'd4);
    @(negedge clk);
    chk("t3_rd_en_low", 32'(fifo_rd_en), 32'd0);
    chk("t3_tvalid", 32'(m_tvalid), 32'd1);
    chk("t3_tdata", m_tdata, 32'd200);
    chk("t3_tuser", 32'(m_tuser), 32'd1);
    chk("t3_err_ov", 32'(err_ov), 32'd0);
    tick();
    clear_beats();
    m_tready = 1'b1;
    wait_beats(10, 100);
    for (int i = 0; i < 10 && i < bq_d.size(); i++) begin
      chk("t3_drain", bq_d[i], 32'(200 + i));
      chk("t3_tlast", 32'(bq_l[i]), (i % 4 == 3) ? 32'd1 : 32'd0);
    end

    // Test 4: random ready, 1000 words, order and credit bound (stream position starts at 34)
    repeat (4) tick();
    clear_beats();
    occ_max = 0;
    track = 1'b1;
    for (int i = 0; i < 1000; i++) push_word(32'(1000 + i));
    for (int c = 0; c < 6000 && bq_d.size() < 1000; c++) begin
      m_tready = 1'($urandom_range(0, 1));
      tick();
    end
    m_tready = 1'b1;
    chk("t4_beats", 32'(bq_d.size()), 32'd1000);
    for (int i = 0; i < 1000 && i < bq_d.size(); i++) begin
      pos = 34 + i;
      chk("t4_data", bq_d[i], 32'(1000 + i));
      chk("t4_tlast", 32'(bq_l[i]), (pos % 4 == 3) ? 32'd1 : 32'd0);
      chk("t4_tuser", 32'(bq_u[i]), (pos % 8 == 0) ? 32'd1 : 32'd0);
    end
    repeat (4) tick();
    track = 1'b0;
    chk("t4_occ_le_4", 32'(occ_max <= 4), 32'd1);
    chk("t4_err_sp", 32'(err_sp), 32'd0);
    chk("t4_err_ov", 32'(err_ov), 32'd0);

    // Test 5: spurious rd_valid, sticky, then clr
    enable = 1'b0;
    repeat (4) tick();
    inj_d = 32'hdead;
    inj = 1'b1;
    tick();
    inj = 1'b0;
    chk("t5_err_sp_set", 32'(err_sp), 32'd1);
    repeat (5) tick();
    chk("t5_err_sp_sticky", 32'(err_sp), 32'd1);
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("t5_clr_err_sp", 32'(err_sp), 32'd0);
    chk("t5_clr_tuser", 32'(m_tuser), 32'd1);
    chk("t5_clr_tvalid", 32'(m_tvalid), 32'd0);
    clear_beats();
    enable = 1'b1;
    push_word(32'd300);
    wait_beats(1, 20);
    if (bq_d.size() > 0) begin
      chk("t5_next_data", bq_d[0], 32'd300);
      chk("t5_next_tuser", 32'(bq_u[0]), 32'd1);
    end

    // Overrun: five returns with nothing in flight and ready low
    enable = 1'b0;
    m_tready = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < 5; i++) begin
      inj_d = 32'(400 + i);
      inj = 1'b1;
      tick();
    end
    inj = 1'b0;
    chk("ov_err_ov", 32'(err_ov), 32'd1);
    chk("ov_err_sp", 32'(err_sp), 32'd1);
    chk("ov_tvalid", 32'(m_tvalid), 32'd1);
    chk("ov_tdata", m_tdata, 32'd400);
    clear_beats();
    m_tready = 1'b1;
    wait_beats(4, 20);
    repeat (3) tick();
    chk("ov_beats_total", 32'(bq_d.size()), 32'd4);
    for (int i = 0; i < 4 && i < bq_d.size(); i++) chk("ov_data", bq_d[i], 32'(400 + i));
    clr = 1'b1;
    tick();
    clr = 1'b0;
    chk("ov_clr_err_ov", 32'(err_ov), 32'd0);

    // Test 6: async reset mid-line with 3 words buffered
    enable = 1'b1;
    clear_beats();
    push_word(32'd600);
    push_word(32'd601);
    wait_beats(2, 20);
    m_tready = 1'b0;
    push_word(32'd602);
    push_word(32'd603);
    push_word(32'd604);
    repeat (10) tick();
    chk("t6_tvalid_pre", 32'(m_tvalid), 32'd1);
    chk("t6_tdata_pre", m_tdata, 32'd602);
    chk("t6_tuser_pre", 32'(m_tuser), 32'd0);
    #2;
    a_rstn = 1'b0;
    #1;
    chk("t6_rst_tvalid", 32'(m_tvalid), 32'd0);
    chk("t6_rst_tuser", 32'(m_tuser), 32'd1);
    chk("t6_rst_tdata", m_tdata, 32'd0);
    tick();
    a_rstn = 1'b1;
    clear_beats();
    m_tready = 1'b1;
    push_word(32'd700);
    wait_beats(1, 30);
    if (bq_d.size() > 0) begin
      chk("t6_next_data", bq_d[0], 32'd700);
      chk("t6_next_tuser", 32'(bq_u[0]), 32'd1);
    end
    chk("t6_err_sp", 32'(err_sp), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
